// File: rtl/if_fetch_queue.sv
// if_fetch_queue
// Instruction fetch unit with a small instruction queue in front of decode.
// A fetch PC issues word requests to instruction memory under a credit rule
// (queued entries plus the one possibly in flight never exceed DEPTH), so the
// queue can never overflow. Responses arrive exactly one cycle after each
// grant and are pushed with the address that was granted. A branch redirect
// flushes the queue, drops the response in flight and restarts fetch at the
// target on the following cycle.
//
// Parameters
//   DEPTH     queue depth in entries (power of two, >= 2)
//   RESET_PC  first byte address fetched after reset
// Ports
//   clk, rst                     clock, synchronous active-high reset
//   imem_req/addr/gnt            fetch request handshake to instruction memory
//   imem_rvalid/rdata            fetch response, one cycle after each grant
//   id_valid/instr/pc, id_ready  queue head handshake towards decode
//   br_taken/br_target           one-cycle redirect from execute
//   halt                         level; suppresses new fetches while high
module if_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  input  logic        id_ready,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        halt
);

  localparam int             PTR_W     = $clog2(DEPTH);
  localparam logic [PTR_W:0] DEPTH_L   = (PTR_W + 1)'(DEPTH);
  localparam logic [31:0]    WORD_MASK = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_STALL    = 2'd1,
    ST_HALT     = 2'd2,
    ST_REDIRECT = 2'd3
  } state_t;

  logic [31:0]    fetch_pc_r;
  logic [31:0]    rsp_pc_r;
  logic           inflight_r;
  logic [PTR_W:0] count_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W-1:0] wr_ptr_r;
  logic [31:0]    pc_mem_r    [DEPTH];
  logic [31:0]    instr_mem_r [DEPTH];
  state_t         state_r;
  state_t         state_next_s;

  logic [PTR_W:0] credit_used_s;
  logic           grant_s;
  logic           push_s;
  logic           pop_s;
  logic           head_valid_s;

  // Credit: entries already queued plus the response that may land this cycle.
  assign credit_used_s = count_r + {{PTR_W{1'b0}}, inflight_r};
  assign imem_req      = !rst && !halt && !br_taken && (credit_used_s < DEPTH_L);
  assign imem_addr     = fetch_pc_r;
  assign grant_s       = imem_req && imem_gnt;

  // A response is only accepted if it belongs to a grant made last cycle and
  // that grant was not overtaken by a redirect or reset in between.
  assign push_s = imem_rvalid && inflight_r && (state_r != ST_REDIRECT) &&
                  !br_taken && !rst;

  assign head_valid_s = !rst && (count_r != {(PTR_W + 1){1'b0}});
  assign pop_s        = head_valid_s && id_ready && !br_taken;

  assign id_valid = head_valid_s;
  assign id_instr = head_valid_s ? instr_mem_r[rd_ptr_r] : 32'h0000_0000;
  assign id_pc    = head_valid_s ? pc_mem_r[rd_ptr_r]    : 32'h0000_0000;

  // Next fetch state; reset also lands in REDIRECT so a pending word is dropped.
  always_comb begin
    state_next_s = state_r;
    if (rst || br_taken) begin
      state_next_s = ST_REDIRECT;
    end else if (halt) begin
      state_next_s = ST_HALT;
    end else if (grant_s) begin
      state_next_s = ST_RUN;
    end else begin
      state_next_s = ST_STALL;
    end
  end

  // Fetch state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_REDIRECT;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Fetch PC, in-flight tracking and queue pointers/occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_r <= RESET_PC & WORD_MASK;
      rsp_pc_r   <= 32'h0000_0000;
      inflight_r <= 1'b0;
      count_r    <= {(PTR_W + 1){1'b0}};
      rd_ptr_r   <= {PTR_W{1'b0}};
      wr_ptr_r   <= {PTR_W{1'b0}};
    end else if (br_taken) begin
      // Flush wins over any coincident push or pop.
      fetch_pc_r <= br_target & WORD_MASK;
      inflight_r <= 1'b0;
      count_r    <= {(PTR_W + 1){1'b0}};
      rd_ptr_r   <= {PTR_W{1'b0}};
      wr_ptr_r   <= {PTR_W{1'b0}};
    end else begin
      inflight_r <= grant_s;
      if (grant_s) begin
        fetch_pc_r <= fetch_pc_r + 32'd4;
        rsp_pc_r   <= fetch_pc_r;
      end
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1'b1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + {{PTR_W{1'b0}}, 1'b1};
        2'b01:   count_r <= count_r - {{PTR_W{1'b0}}, 1'b1};
        default: count_r <= count_r;
      endcase
    end
  end

  // Queue storage; contents need no reset because occupancy guards the reads.
  always_ff @(posedge clk) begin
    if (push_s) begin
      pc_mem_r[wr_ptr_r]    <= rsp_pc_r;
      instr_mem_r[wr_ptr_r] <= imem_rdata;
    end
  end

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed testbench for if_fetch_queue (DEPTH=4, RESET_PC=0). The bench acts
// as instruction memory: a grant seen in one cycle produces imem_rvalid with
// word 32'h00a00093 + (addr >> 2) in the next. Inputs change and outputs are
// sampled just after the falling clock edge.
module tb_if_fetch_queue;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic        id_ready;
  logic        br_taken;
  logic [31:0] br_target;
  logic        halt;

  int          checks;
  int          failures;
  int          grants;
  logic [31:0] q_pc[$];
  logic [31:0] q_instr[$];

  if_fetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc), .id_ready(id_ready),
    .br_taken(br_taken), .br_target(br_target), .halt(halt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h00a00093 + (a >> 2);
  endfunction

  // One clock: note this cycle's grant and delivery, then play memory response.
  task automatic cycle();
    logic        g;
    logic [31:0] a;
    g = imem_req && imem_gnt;
    a = imem_addr;
    if (g) grants++;
    if (id_valid && id_ready && !br_taken && !rst) begin
      q_pc.push_back(id_pc);
      q_instr.push_back(id_instr);
    end
    @(posedge clk);
    @(negedge clk);
    imem_rvalid = g;
    imem_rdata  = g ? mem_word(a) : 32'hdead_beef;
    br_taken    = 1'b0;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; halt = 1'b0; br_taken = 1'b0; id_ready = 1'b0; imem_gnt = 1'b0;
    cycle();
    cycle();
    rst = 1'b0;
    grants = 0;
    q_pc.delete();
    q_instr.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1; imem_gnt = 1'b1; id_ready = 1'b1;
    #1;
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL reset_req got=%0b exp=0", imem_req); end
    checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", id_valid); end
    cycle();
    cycle();
    checks++; if (id_instr !== 32'h0) begin failures++; $display("FAIL reset_instr got=%h exp=0", id_instr); end
    checks++; if (id_pc !== 32'h0) begin failures++; $display("FAIL reset_pc got=%h exp=0", id_pc); end
    rst = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL reset_first_req got=%0b exp=1", imem_req); end
    checks++; if (imem_addr !== 32'h0) begin failures++; $display("FAIL reset_first_addr got=%h exp=0", imem_addr); end
    checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL reset_empty got=%0b exp=0", id_valid); end
  endtask

  task automatic test_streaming();
    do_reset();
    imem_gnt = 1'b1; id_ready = 1'b1;
    #1;
    for (int k = 0; k < 10; k++) begin
      checks++; if (imem_addr !== 32'(4 * k)) begin failures++; $display("FAIL stream_addr k=%0d got=%h exp=%h", k, imem_addr, 32'(4 * k)); end
      if (k >= 2) begin
        checks++; if (id_valid !== 1'b1) begin failures++; $display("FAIL stream_valid k=%0d got=%0b exp=1", k, id_valid); end
        checks++; if (id_pc !== 32'(4 * (k - 2))) begin failures++; $display("FAIL stream_pc k=%0d got=%h exp=%h", k, id_pc, 32'(4 * (k - 2))); end
        checks++; if (id_instr !== mem_word(32'(4 * (k - 2)))) begin failures++; $display("FAIL stream_instr k=%0d got=%h exp=%h", k, id_instr, mem_word(32'(4 * (k - 2)))); end
      end else begin
        checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL stream_startup k=%0d got=%0b exp=0", k, id_valid); end
      end
      cycle();
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    imem_gnt = 1'b1; id_ready = 1'b0;
    #1;
    repeat (10) cycle();
    checks++; if (grants !== 4) begin failures++; $display("FAIL bp_grants got=%0d exp=4", grants); end
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL bp_req_drop got=%0b exp=0", imem_req); end
    checks++; if (dut.count_r !== 3'd4) begin failures++; $display("FAIL bp_occupancy got=%0d exp=4", dut.count_r); end
    id_ready = 1'b1;
    #1;
    for (int k = 0; k < 6; k++) begin
      checks++; if (id_valid !== 1'b1) begin failures++; $display("FAIL bp_drain_valid k=%0d got=%0b exp=1", k, id_valid); end
      checks++; if (id_pc !== 32'(4 * k)) begin failures++; $display("FAIL bp_drain_pc k=%0d got=%h exp=%h", k, id_pc, 32'(4 * k)); end
      cycle();
    end
  endtask

  task automatic test_redirect();
    do_reset();
    imem_gnt = 1'b1; id_ready = 1'b0;
    #1;
    repeat (4) cycle();
    // Queue now holds pcs 0,4,8; the word for pc 12 lands in this cycle.
    checks++; if (dut.count_r !== 3'd3) begin failures++; $display("FAIL br_pre_occupancy got=%0d exp=3", dut.count_r); end
    id_ready = 1'b1; br_taken = 1'b1; br_target = 32'h0000_0026;
    #1;
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL br_req_in_br got=%0b exp=0", imem_req); end
    cycle();
    checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL br_flush_valid got=%0b exp=0", id_valid); end
    checks++; if (imem_addr !== 32'h24) begin failures++; $display("FAIL br_target_addr got=%h exp=00000024", imem_addr); end
    checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL br_restart_req got=%0b exp=1", imem_req); end
    checks++; if (q_pc.size() !== 0) begin failures++; $display("FAIL br_pop_ignored got=%0d exp=0", q_pc.size()); end
    repeat (6) cycle();
    checks++; if (q_pc.size() !== 4) begin failures++; $display("FAIL br_deliv_count got=%0d exp=4", q_pc.size()); end
    for (int i = 0; i < q_pc.size(); i++) begin
      checks++; if (q_pc[i] !== 32'(32'h24 + 4 * i)) begin failures++; $display("FAIL br_deliv_pc i=%0d got=%h exp=%h", i, q_pc[i], 32'(32'h24 + 4 * i)); end
      checks++; if (q_instr[i] !== mem_word(32'(32'h24 + 4 * i))) begin failures++; $display("FAIL br_deliv_instr i=%0d got=%h exp=%h", i, q_instr[i], mem_word(32'(32'h24 + 4 * i))); end
    end
  endtask

  task automatic test_halt();
    do_reset();
    imem_gnt = 1'b1; id_ready = 1'b0;
    #1;
    cycle();
    halt = 1'b1;
    #1;
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL halt_req got=%0b exp=0", imem_req); end
    repeat (4) cycle();
    checks++; if (grants !== 1) begin failures++; $display("FAIL halt_grants got=%0d exp=1", grants); end
    checks++; if (id_valid !== 1'b1) begin failures++; $display("FAIL halt_enq_valid got=%0b exp=1", id_valid); end
    checks++; if (id_pc !== 32'h0) begin failures++; $display("FAIL halt_enq_pc got=%h exp=0", id_pc); end
    checks++; if (id_instr !== 32'h00a00093) begin failures++; $display("FAIL halt_enq_instr got=%h exp=00a00093", id_instr); end
    halt = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL halt_resume_req got=%0b exp=1", imem_req); end
    checks++; if (imem_addr !== 32'h4) begin failures++; $display("FAIL halt_resume_addr got=%h exp=00000004", imem_addr); end
    // Redirect while halted: PC moves, but nothing is requested until release.
    halt = 1'b1; br_taken = 1'b1; br_target = 32'h0000_0103;
    #1;
    cycle();
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL halt_br_req got=%0b exp=0", imem_req); end
    checks++; if (imem_addr !== 32'h100) begin failures++; $display("FAIL halt_br_addr got=%h exp=00000100", imem_addr); end
    checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL halt_br_flush got=%0b exp=0", id_valid); end
    halt = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL halt_br_release got=%0b exp=1", imem_req); end
  endtask

  task automatic test_reset_midrun();
    do_reset();
    imem_gnt = 1'b1; id_ready = 1'b1;
    #1;
    repeat (16) cycle();
    checks++; if (imem_addr !== 32'h40) begin failures++; $display("FAIL mid_pre_addr got=%h exp=00000040", imem_addr); end
    rst = 1'b1;
    #1;
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL mid_rst_req got=%0b exp=0", imem_req); end
    checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL mid_rst_valid got=%0b exp=0", id_valid); end
    cycle();
    rst = 1'b0;
    q_pc.delete();
    q_instr.delete();
    #1;
    checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL mid_resume_req got=%0b exp=1", imem_req); end
    checks++; if (imem_addr !== 32'h0) begin failures++; $display("FAIL mid_resume_addr got=%h exp=0", imem_addr); end
    checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL mid_resume_empty got=%0b exp=0", id_valid); end
    repeat (4) cycle();
    checks++; if (q_pc.size() !== 2) begin failures++; $display("FAIL mid_deliv_count got=%0d exp=2", q_pc.size()); end
    for (int i = 0; i < q_pc.size(); i++) begin
      checks++; if (q_pc[i] !== 32'(4 * i)) begin failures++; $display("FAIL mid_deliv_pc i=%0d got=%h exp=%h", i, q_pc[i], 32'(4 * i)); end
    end
  endtask

  task automatic test_grant_stall();
    do_reset();
    id_ready = 1'b1;
    for (int k = 0; k < 14; k++) begin
      imem_gnt = (k % 2 == 0);
      #1;
      checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL gs_req k=%0d got=%0b exp=1", k, imem_req); end
      checks++; if (imem_addr !== 32'(4 * ((k + 1) / 2))) begin failures++; $display("FAIL gs_addr k=%0d got=%h exp=%h", k, imem_addr, 32'(4 * ((k + 1) / 2))); end
      cycle();
    end
    checks++; if (q_pc.size() !== 6) begin failures++; $display("FAIL gs_deliv_count got=%0d exp=6", q_pc.size()); end
    for (int i = 0; i < q_pc.size(); i++) begin
      checks++; if (q_pc[i] !== 32'(4 * i)) begin failures++; $display("FAIL gs_deliv_pc i=%0d got=%h exp=%h", i, q_pc[i], 32'(4 * i)); end
    end
  endtask

  initial begin
    checks = 0; failures = 0; grants = 0;
    rst = 1'b1; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    id_ready = 1'b0; br_taken = 1'b0; br_target = 32'h0; halt = 1'b0;
    @(negedge clk);
    #1;
    test_reset();
    test_streaming();
    test_backpressure();
    test_redirect();
    test_halt();
    test_reset_midrun();
    test_grant_stall();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
